// File: rtl/vjtag_pkg.sv
// ----------------------------------------------------------------------------
// vjtag_pkg: shared types and frame layout for the virtual-JTAG DR master. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vjtag_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    IR     = 2'b01,
    MEM    = 2'b11
  } jtag_instr_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RSP  = 3'd5
  } vjm_state_e;

  localparam int DR_LEN   = 16;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;

  function automatic logic instr_legal(input logic [1:0] instr);
    return (instr == IR) || (instr == MEM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vjtag_dr_master_if.sv
// ----------------------------------------------------------------------------
// vjtag_dr_master_if: command/response bus plus virtual-JTAG strobes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vjtag_dr_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_instr;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [1:0]        ir_in;
  logic              v_uir;
  logic              v_cdr;
  logic              v_sdr;
  logic              v_udr;
  logic              tdi;
  logic              tdo;

  modport master (
    input  cmd_valid, cmd_instr, cmd_write, cmd_addr, cmd_data, tdo,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output ir_in, v_uir, v_cdr, v_sdr, v_udr, tdi
  );

  modport slave (
    output cmd_valid, cmd_instr, cmd_write, cmd_addr, cmd_data, tdo,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  ir_in, v_uir, v_cdr, v_sdr, v_udr, tdi
  );

endinterface

`default_nettype wire

// File: rtl/vjtag_dr_master.sv
// ----------------------------------------------------------------------------
// vjtag_dr_master: runs one IR-update/capture/16-bit shift/update DR frame per command. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vjtag_dr_master
  import vjtag_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              tck,
  input  logic              aclr,
  vjtag_dr_master_if.master bus
);

  vjm_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [DR_LEN-1:0] frame_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hold_mem_q;
  logic [3:0]        hold_ir_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        ir_in_q;
  logic              uir_q;
  logic              cdr_q;
  logic              sdr_q;
  logic              udr_q;

  logic [DR_LEN-1:0] frame_d;
  logic [7:0]        addr_field;
  logic              accept;

  assign accept = bus.cmd_valid && cmd_ready_q;

  // Reads re-shift the held pointer so the responder's update rewrites the same byte.
  always_comb begin
    addr_field = 8'h00;
    frame_d    = '0;
    if (bus.cmd_write) begin
      addr_field = (bus.cmd_instr == IR) ? {4'h0, bus.cmd_addr[3:0]} : 8'(bus.cmd_addr);
      frame_d[DATA_LSB +: 8] = 8'(bus.cmd_data);
    end else begin
      addr_field = (bus.cmd_instr == IR) ? {4'h0, hold_ir_q} : hold_mem_q;
    end
    frame_d[ADDR_LSB +: 8] = addr_field;
  end

  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      frame_q     <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      hold_mem_q  <= 8'h00;
      hold_ir_q   <= 4'h0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      ir_in_q     <= 2'b00;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            write_q     <= bus.cmd_write;
            addr_q      <= bus.cmd_addr;
            frame_q     <= frame_d;
            cnt_q       <= 4'd0;
            if (!instr_legal(bus.cmd_instr)) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.cmd_instr != ir_in_q) begin
              state_q <= UIR;
              uir_q   <= 1'b1;
              ir_in_q <= bus.cmd_instr;
            end else begin
              state_q <= CDR;
              cdr_q   <= 1'b1;
            end
          end
        end
        UIR: begin
          state_q <= CDR;
          cdr_q   <= 1'b1;
        end
        CDR: begin
          state_q <= SDR;
          sdr_q   <= 1'b1;
        end
        SDR: begin
          if (!cnt_q[3]) begin
            rsp_data_q[cnt_q[2:0]] <= bus.tdo;
          end
          frame_q <= frame_q >> 1;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= UDR;
            sdr_q   <= 1'b0;
            udr_q   <= 1'b1;
          end
        end
        UDR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          if (write_q) begin
            if (ir_in_q == IR) begin
              hold_ir_q <= addr_q[3:0];
            end else begin
              hold_mem_q <= addr_q[7:0];
            end
          end
        end
        RSP: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          sdr_q       <= 1'b0;
        end
      endcase
    end
  end

  // Echo path: during the data half of a read, captured bits go straight back out.
  assign bus.tdi = sdr_q & ((!write_q && !cnt_q[3]) ? bus.tdo : frame_q[0]);

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.ir_in     = ir_in_q;
  assign bus.v_uir     = uir_q;
  assign bus.v_cdr     = cdr_q;
  assign bus.v_sdr     = sdr_q;
  assign bus.v_udr     = udr_q;

endmodule

`default_nettype wire

// File: tb/tb_vjtag_dr_master.sv
// ----------------------------------------------------------------------------
// tb_vjtag_dr_master: DR master driven against a behavioural responder and command-level model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vjtag_dr_master;
  import vjtag_pkg::*;

  logic tck  = 1'b0;
  logic aclr = 1'b0;
  always #5 tck = ~tck;

  vjtag_dr_master_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  vjtag_dr_master #(.DATA_W(8), .ADDR_W(8)) u_dut (
    .tck  (tck),
    .aclr (aclr),
    .bus  (bus)
  );

  // Responder: captures {pointer, data}, shifts LSB first, updates byte and pointer.
  logic [7:0]  r_mem [256];
  logic [7:0]  r_reg [16];
  logic [7:0]  r_pmem;
  logic [3:0]  r_preg;
  logic [15:0] r_sr;

  assign bus.tdo = r_sr[0];

  always @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < 256; i++) r_mem[i] <= 8'h00;
      for (int i = 0; i < 16; i++)  r_reg[i] <= 8'h00;
      r_pmem <= 8'h00;
      r_preg <= 4'h0;
      r_sr   <= 16'h0000;
    end else if (bus.v_cdr) begin
      if (bus.ir_in == IR)       r_sr <= {4'h0, r_preg, r_reg[r_preg]};
      else if (bus.ir_in == MEM) r_sr <= {r_pmem, r_mem[r_pmem]};
      else                       r_sr <= 16'h0000;
    end else if (bus.v_sdr) begin
      r_sr <= {bus.tdi, r_sr[15:1]};
    end else if (bus.v_udr) begin
      if (bus.ir_in == IR) begin
        r_reg[r_sr[11:8]] <= r_sr[7:0];
        r_preg            <= r_sr[11:8];
      end else if (bus.ir_in == MEM) begin
        r_mem[r_sr[15:8]] <= r_sr[7:0];
        r_pmem            <= r_sr[15:8];
      end
    end
  end

  // Command-level reference state.
  logic [7:0] m_mem [256];
  logic [7:0] m_reg [16];
  logic [7:0] m_pmem;
  logic [3:0] m_preg;
  logic [1:0] m_ir;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cmd_no = 0;
  int         last_gap;
  logic [7:0] last_rsp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++)  m_reg[i] = 8'h00;
    m_pmem = 8'h00;
    m_preg = 4'h0;
    m_ir   = 2'b00;
  endtask

  task automatic run_cmd(input logic [1:0] ins, input logic wr, input logic [7:0] ad,
                         input logic [7:0] dt, input logic drop);
    logic        legal, exp_uir, seen, got_e;
    logic [7:0]  ptr, old, got_d;
    logic [15:0] exp_frame, obs_frame;
    int          exp_lat, lat, n_uir, n_cdr, n_sdr, n_udr, n_clash;
    string       t;

    legal     = (ins == 2'b01) || (ins == 2'b11);
    exp_uir   = legal && (ins != m_ir);
    ptr       = (ins == 2'b01) ? {4'h0, m_preg} : m_pmem;
    old       = !legal ? 8'h00 : ((ins == 2'b01) ? m_reg[m_preg] : m_mem[m_pmem]);
    exp_frame = wr ? {((ins == 2'b01) ? {4'h0, ad[3:0]} : ad), dt} : {ptr, old};
    exp_lat   = !legal ? 1 : (exp_uir ? 20 : 19);
    if (legal) begin
      m_ir = ins;
      if (wr && ins == 2'b01) begin
        m_reg[ad[3:0]] = dt;
        m_preg         = ad[3:0];
      end else if (wr) begin
        m_mem[ad] = dt;
        m_pmem    = ad;
      end
    end
    cmd_no++;
    t = $sformatf("c%0d", cmd_no);

    @(negedge tck);
    bus.cmd_instr = ins;
    bus.cmd_write = wr;
    bus.cmd_addr  = ad;
    bus.cmd_data  = dt;
    bus.cmd_valid = 1'b1;
    last_gap = 0;
    while (!bus.cmd_ready && last_gap < 40) begin
      @(negedge tck);
      last_gap++;
    end
    @(posedge tck);
    #1;
    // Fields are don't-care after accept; scramble them to prove they are held.
    bus.cmd_instr = 2'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_data  = 8'($urandom);

    seen = 1'b0; got_d = 8'h00; got_e = 1'b0; obs_frame = 16'h0000;
    lat = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_clash = 0;
    while (!seen && lat < 40) begin
      @(negedge tck);
      lat++;
      n_uir += int'(bus.v_uir);
      n_cdr += int'(bus.v_cdr);
      n_udr += int'(bus.v_udr);
      if (bus.v_sdr) begin
        if (n_sdr < 16) obs_frame[n_sdr[3:0]] = bus.tdi;
        n_sdr++;
      end
      if ((int'(bus.v_uir) + int'(bus.v_cdr) + int'(bus.v_sdr) + int'(bus.v_udr)
           + int'(bus.rsp_valid)) > 1 || bus.cmd_ready)
        n_clash++;
      if (bus.rsp_valid) begin
        seen  = 1'b1;
        got_d = bus.rsp_data;
        got_e = bus.rsp_err;
      end
    end
    if (drop) bus.cmd_valid = 1'b0;

    chk({t, "_rsp_seen"}, 32'(seen), 32'd1);
    chk({t, "_latency"},  32'(lat), 32'(exp_lat));
    chk({t, "_rsp_data"}, 32'(got_d), 32'(old));
    chk({t, "_rsp_err"},  32'(got_e), 32'(!legal));
    chk({t, "_uir_cnt"},  32'(n_uir), 32'(exp_uir));
    chk({t, "_cdr_cnt"},  32'(n_cdr), legal ? 32'd1 : 32'd0);
    chk({t, "_sdr_cnt"},  32'(n_sdr), legal ? 32'd16 : 32'd0);
    chk({t, "_udr_cnt"},  32'(n_udr), legal ? 32'd1 : 32'd0);
    chk({t, "_overlap"},  32'(n_clash), 32'd0);
    chk({t, "_ir_in"},    32'(bus.ir_in), 32'(m_ir));
    if (legal) chk({t, "_tdi_frame"}, 32'(obs_frame), 32'(exp_frame));
    last_rsp = got_d;
  endtask

  logic [1:0] ins;
  logic       wr, drop, prev_drop;
  logic [7:0] ad, dt;
  int         sel, n, tmo, diffs;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_instr = 2'b00;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge tck);
    aclr = 1'b1;
    @(negedge tck);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_ir_in",     32'(bus.ir_in), 32'd0);
    chk("rst_strobes",   32'({bus.v_uir, bus.v_cdr, bus.v_sdr, bus.v_udr, bus.tdi}), 32'd0);
    chk("rst_rsp",       32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 32'd0);

    run_cmd(MEM, 1'b1, 8'h3C, 8'hA5, 1'b1);
    chk("w1_resp_mem", 32'(r_mem[8'h3C]), 32'hA5);
    chk("w1_ir_in",    32'(bus.ir_in), 32'h3);

    run_cmd(MEM, 1'b1, 8'h3C, 8'h5A, 1'b1);
    run_cmd(MEM, 1'b0, 8'hE1, 8'h00, 1'b1);
    chk("r1_data",     32'(last_rsp), 32'h5A);
    chk("r1_resp_mem", 32'(r_mem[8'h3C]), 32'h5A);

    run_cmd(IR, 1'b1, 8'h07, 8'h81, 1'b1);
    run_cmd(IR, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("ir_read_data", 32'(last_rsp), 32'h81);
    chk("ir_reg7",      32'(r_reg[7]), 32'h81);
    run_cmd(MEM, 1'b1, 8'h10, 8'h33, 1'b1);
    run_cmd(IR, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("ir_reread", 32'(last_rsp), 32'h81);

    run_cmd(MEM, 1'b1, 8'h00, 8'h11, 1'b0);
    run_cmd(MEM, 1'b1, 8'hFF, 8'h22, 1'b1);
    chk("b2b_gap",  32'(last_gap), 32'd0);
    chk("b2b_rsp",  32'(last_rsp), 32'h11);

    run_cmd(2'b10, 1'b1, 8'h55, 8'h66, 1'b1);

    prev_drop = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 9);
      ins  = (sel < 4) ? MEM : (sel < 8) ? IR : (sel == 8) ? 2'b10 : 2'b00;
      wr   = 1'($urandom_range(0, 1));
      ad   = 8'($urandom);
      dt   = 8'($urandom);
      drop = (i == 39) || ($urandom_range(0, 3) == 0);
      run_cmd(ins, wr, ad, dt, drop);
      if (!prev_drop) chk("rnd_b2b_gap", 32'(last_gap), 32'd0);
      prev_drop = drop;
      if (drop) repeat ($urandom_range(1, 3)) @(negedge tck);
    end

    // Abort mid-shift at k=9.
    @(negedge tck);
    bus.cmd_instr = MEM;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h77;
    bus.cmd_data  = 8'h99;
    bus.cmd_valid = 1'b1;
    tmo = 0;
    while (!bus.cmd_ready && tmo < 40) begin
      @(negedge tck);
      tmo++;
    end
    @(posedge tck);
    #1 bus.cmd_valid = 1'b0;
    n = 0; tmo = 0;
    while (n < 10 && tmo < 40) begin
      @(negedge tck);
      tmo++;
      if (bus.v_sdr) n++;
    end
    chk("abort_reach_k9", 32'(n), 32'd10);
    aclr = 1'b0;
    #1;
    chk("abort_outputs", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.ir_in, bus.v_uir,
                              bus.v_cdr, bus.v_sdr, bus.v_udr, bus.tdi}), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.cmd_ready), 32'd1);
    @(negedge tck);
    @(negedge tck);
    aclr = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge tck);
      n += int'(bus.v_udr) + int'(bus.rsp_valid);
    end
    chk("abort_no_udr", 32'(n), 32'd0);
    chk("abort_ready",  32'(bus.cmd_ready), 32'd1);
    model_reset();
    run_cmd(MEM, 1'b0, 8'h00, 8'h00, 1'b1);
    run_cmd(MEM, 1'b1, 8'h12, 8'h34, 1'b1);
    run_cmd(MEM, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("post_abort_read", 32'(last_rsp), 32'h34);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (r_mem[i] !== m_mem[i]) diffs++;
    chk("final_mem_diff", 32'(diffs), 32'd0);
    diffs = 0;
    for (int i = 0; i < 16; i++) if (r_reg[i] !== m_reg[i]) diffs++;
    chk("final_reg_diff", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/vjtag_dr_master.md
# vjtag_dr_master

Initiator for the virtual-JTAG data-register protocol: it drives the `ir_in`/`v_uir`/`v_cdr`/`v_sdr`/`v_udr`/`tdi` strobes and samples `tdo`, so the design's JTAG DR responder can be exercised from logic or test firmware on the same `tck` domain. Each accepted command is one complete DR frame: optional IR update, capture, 16-bit LSB-first shift, and update. Reads are non-destructive because captured data bits are echoed back during the shift.

## Interface
- DATA_W, 8, data field width (bits [7:0] of the frame)
- ADDR_W, 8, MEM address field width (bits [15:8]); IR index uses bits [11:8], and bits [15:12] are shifted as 0
- tck  in  1  clock; all state changes on posedge
- aclr  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_instr  in  2  2'b01 = IR (register file), 2'b11 = MEM; any other value is illegal
- cmd_write  in  1  1 = write frame, 0 = read frame
- cmd_addr  in  ADDR_W  target address (MEM) or index in [3:0] (IR); used by writes only
- cmd_data  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, one per accepted command
- rsp_data  out  DATA_W  byte captured during the frame
- rsp_err  out  1  valid with rsp_valid; set for an illegal instr
- ir_in  out  2  current instruction
- v_uir, v_cdr, v_sdr, v_udr  out  1 each  update-IR, capture-DR, shift-DR and update-DR strobes
- tdi  out  1  serial data to responder
- tdo  in  1  serial data from responder

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RSP.
- Accept: `cmd_valid && cmd_ready` latches the command. An illegal instr goes directly to RSP with rsp_err=1 and rsp_data=0; no strobes are driven.
- IDLE→UIR only if cmd_instr≠ir_in. UIR lasts 1 cycle: v_uir=1 and ir_in takes the new value. Otherwise IDLE→CDR directly.
- CDR: 1 cycle, v_cdr=1.
- SDR: 16 cycles, v_sdr=1, with a 4-bit counter k=0..15. The frame shifted is F = {held_addr_field, data_field}, LSB first.
  - Write: F = {cmd_addr (IR: 4'b0, idx), cmd_data}. tdi=F[k].
  - Read: bits k<8 use tdi = tdo (echo, combinational; this is the only comb path). Bits k≥8 re-shift the held pointer, so the update rewrites the same byte unchanged.
  - In all modes, tdo is sampled at the posedge ending cycle k into rsp_data[k] for k<8.
- UDR: 1 cycle, v_udr=1. After a write, the held pointer for that instr becomes cmd_addr.
- RSP: 1 cycle, rsp_valid=1, then IDLE.
- Held pointers: hold_mem[7:0] and hold_ir[3:0], one per instr. A read always targets the held pointer; cmd_addr is ignored for reads. To read address A, the caller writes A first, or uses the value returned by that write (the capture returns the old content at the previously held address).

## Timing
- Reset values: all strobes, tdi, rsp_valid, rsp_err and rsp_data are 0. ir_in=2'b00. Pointers are 0. State is IDLE and cmd_ready=1. These match the responder's reset contents.
- All outputs except tdi are registered. Strobes are asserted for whole cycles and are mutually exclusive.
- Latency from accept edge to rsp_valid: 19 cycles without an IR change, 20 with one. An illegal command takes 1 cycle.
- cmd_ready=0 from accept until RSP completes. cmd_ready can next rise in the cycle after rsp_valid, so commands can run back-to-back.
- cmd_* inputs are don't-care when not accepted. Command fields are held internally for the whole frame.
- aclr asserted mid-frame aborts immediately: no rsp_valid, no v_udr. The responder is reset on the same aclr.

## Structure
- Shared package `vjtag_pkg`:
  - `jtag_instr_e` (BYPASS=2'b00, IR=2'b01, MEM=2'b11)
  - state enum `vjm_state_e`
  - localparams DR_LEN=16, DATA_LSB=0, ADDR_LSB=8
- Single module with no sub-modules. One small FSM, a shift counter, and a 16-bit frame register shifted right.

## Test plan
- Reset then write MEM 0x3C←0xA5 -> ir_in goes 00→11 with a 1-cycle v_uir; rsp_valid at cycle 20; responder mem[0x3C]=0xA5.
- Write MEM 0x3C←0x5A, then read MEM -> the read has no v_uir, rsp_data=0x5A at cycle 19, and mem[0x3C] stays 0x5A after v_udr.
- Write IR idx 7←0x81, then read IR -> rsp_data=0x81 and regfile[7] is unchanged. An interleaved MEM write causes a v_uir on each instr switch.
- Back-to-back writes 0x00←0x11 and 0xFF←0x22 with cmd_valid held high -> second accept in the cycle after the first rsp_valid; the second write's rsp_data is 0x11.
- Command with cmd_instr=2'b10 -> no strobes, rsp_valid with rsp_err=1 one cycle after accept.
- aclr pulsed low during SDR cycle k=9 -> all outputs go to 0 asynchronously, no v_udr, and cmd_ready=1 after release.
